// File: rtl/alu_muldiv.sv
// Registered EX-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops finish at the accept edge; MULT/DIV hold in_ready low for WIDTH+1 cycles.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MFHI = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

  function automatic logic [W-1:0] abs_mag(input logic [W-1:0] v, input logic sgn);
    return (sgn && v[W-1]) ? (~v + W'(1)) : v;
  endfunction

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return ~v + W'(1);
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return ~v + (2*W)'(1);
  endfunction

  // Control state (asynchronously reset)
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    result_q, result_d;
  logic            overflow_q, overflow_d;
  logic            zero_q, zero_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  // Iteration datapath (no reset; always loaded at accept before use)
  logic [W-1:0]    acc_hi_q, acc_hi_d;
  logic [W-1:0]    acc_lo_q, acc_lo_d;
  logic [W-1:0]    mag_b_q, mag_b_d;
  logic [W-1:0]    num1_q, num1_d;
  logic            is_div_q, is_div_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            div0_q, div0_d;

  logic signed [W-1:0] a_s, b_s;
  logic [W-1:0]    add_w, sub_w;
  logic            add_ovf, sub_ovf;
  logic            accept, is_muldiv, op_signed;
  logic            a_neg, b_neg;

  assign a_s       = num1;
  assign b_s       = num2;
  assign add_w     = num1 + num2;
  assign sub_w     = num1 - num2;
  assign add_ovf   = (num1[W-1] == num2[W-1]) && (add_w[W-1] != num1[W-1]);
  assign sub_ovf   = (num1[W-1] != num2[W-1]) && (sub_w[W-1] != num1[W-1]);
  assign accept    = in_valid && (state_q == IDLE);
  assign is_muldiv = (op[3:2] == 2'b10);
  assign op_signed = ~op[0];
  assign a_neg     = op_signed && num1[W-1];
  assign b_neg     = op_signed && num2[W-1];

  // One shift-add or restoring-divide step per BUSY cycle
  logic [W:0]      mul_sum, div_sh, div_diff;
  logic            div_ge;

  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : {(W+1){1'b0}});
  assign div_sh   = {acc_hi_q, acc_lo_q[W-1]};
  assign div_diff = div_sh - {1'b0, mag_b_q};
  assign div_ge   = (div_sh >= {1'b0, mag_b_q});

  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rem_fix;

  assign prod_fix = neg_q_q ? neg_2w({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
  assign quo_fix  = div0_q ? {W{1'b1}} : (neg_q_q ? neg_w(acc_lo_q) : acc_lo_q);
  assign rem_fix  = div0_q ? num1_q    : (neg_r_q ? neg_w(acc_hi_q) : acc_hi_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    mag_b_d     = mag_b_q;
    num1_d      = num1_q;
    is_div_d    = is_div_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    div0_d      = div0_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_muldiv) begin
            state_d  = BUSY;
            cnt_d    = '0;
            is_div_d = op[1];
            neg_q_d  = a_neg ^ b_neg;
            neg_r_d  = a_neg;
            div0_d   = (num2 == '0);
            num1_d   = num1;
            acc_hi_d = '0;
            // Divide shifts the dividend through acc_lo; multiply shifts the multiplier
            acc_lo_d = op[1] ? abs_mag(num1, op_signed) : abs_mag(num2, op_signed);
            mag_b_d  = op[1] ? abs_mag(num2, op_signed) : abs_mag(num1, op_signed);
          end else begin
            out_valid_d = 1'b1;
            overflow_d  = 1'b0;
            unique case (op)
              OP_AND:  result_d = num1 & num2;
              OP_OR:   result_d = num1 | num2;
              OP_ADD:  begin result_d = add_w; overflow_d = add_ovf; end
              OP_SLTU: result_d = {{(W-1){1'b0}}, (num1 < num2)};
              OP_ANDN: result_d = num1 & ~num2;
              OP_ORN:  result_d = num1 | ~num2;
              OP_SUB:  begin result_d = sub_w; overflow_d = sub_ovf; end
              OP_SLT:  result_d = {{(W-1){1'b0}}, (a_s < b_s)};
              OP_MFHI: result_d = hi_q;
              OP_MFLO: result_d = lo_q;
              default: result_d = '0;
            endcase
            zero_d = (result_d == '0);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
          acc_lo_d = {acc_lo_q[W-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
        end
        if (cnt_q == CW'(W-1)) state_d = FIX;
      end
      FIX: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        overflow_d  = 1'b0;
        hi_d        = is_div_q ? rem_fix : prod_fix[2*W-1:W];
        lo_d        = is_div_q ? quo_fix : prod_fix[W-1:0];
        result_d    = lo_d;
        zero_d      = (lo_d == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
    mag_b_q  <= mag_b_d;
    num1_q   <= num1_d;
    is_div_q <= is_div_d;
    neg_q_q  <= neg_q_d;
    neg_r_q  <= neg_r_d;
    div0_q   <= div0_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: the driver pushes hand-computed expectations,
// a negedge monitor pops one per out_valid pulse and checks values and latency.
module tb_alu_muldiv;

  logic        clk, rst;
  logic [31:0] num1, num2;
  logic [3:0]  op;
  logic        in_valid, in_ready;
  logic [31:0] result, hi, lo;
  logic        out_valid, overflow, zero;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .num1(num1), .num2(num2), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .out_valid(out_valid), .overflow(overflow), .zero(zero),
    .hi(hi), .lo(lo)
  );

  typedef struct {
    string       name;
    logic [31:0] res, ehi, elo;
    logic        ovf, z;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] m_hi    = 0;
  logic [31:0] m_lo    = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got result %h expected no output", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".result"}, result, e.res);
        check({e.name, ".overflow"}, {31'b0, overflow}, {31'b0, e.ovf});
        check({e.name, ".zero"}, {31'b0, zero}, {31'b0, e.z});
        check({e.name, ".hi"}, hi, e.ehi);
        check({e.name, ".lo"}, lo, e.elo);
        check({e.name, ".cycle"}, cyc, e.cyc);
      end
    end
  end

  // Called at #1 after an edge; returns at #1 after the accept edge.
  task automatic issue(input string name, input logic [3:0] o, input logic [31:0] a, b,
                       input logic [31:0] er, input logic eo, ez, input int lat, input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.ready_timeout: got in_ready 0 expected 1", name);
    end
    op = o; num1 = a; num2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    e.name = name; e.res = er; e.ovf = eo; e.z = ez;
    e.ehi = m_hi; e.elo = m_lo; e.cyc = cyc + lat;
    sb.push_back(e);
    // Keep presenting other ops while busy; none may be accepted
    for (int i = 0; i < hold; i++) begin
      op = 4'b0010; num1 = $urandom; num2 = $urandom;
      check({name, ".busy_in_ready"}, {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.out_timeout: got out_valid 0 expected 1", name);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 4'd0; num1 = 0; num2 = 0;
    repeat (2) @(posedge clk); #1;
    check("rst.result", result, 32'd0);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.overflow", {31'b0, overflow}, 32'd0);
    check("rst.zero", {31'b0, zero}, 32'd0);
    check("rst.hi", hi, 32'd0);
    check("rst.lo", lo, 32'd0);
    check("rst.in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    issue("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0, 0, 0);
    issue("sub_zero", 4'b0110, 32'd5,        32'd5,        32'h0,        0, 1, 0, 0);
    issue("sub_ovf",  4'b0110, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1, 0, 0, 0);
    issue("slt",      4'b0111, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0, 0);
    issue("sltu",     4'b0011, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1, 0, 0);
    issue("andn",     4'b0100, 32'h0000F0F0, 32'h000000FF, 32'h0000F000, 0, 0, 0, 0);
    issue("orn",      4'b0101, 32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 0, 0, 0, 0);
    issue("and",      4'b0000, 32'h0000FF0F, 32'h000000FF, 32'h0000000F, 0, 0, 0, 0);
    issue("or",       4'b0001, 32'h0000000F, 32'h000000F0, 32'h000000FF, 0, 0, 0, 0);
    issue("rsvd",     4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h0,        0, 1, 0, 0);

    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFA;
    issue("mult",     4'b1000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 0, 0, 33, 10);
    issue("mfhi_m",   4'b1100, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 0, 0);

    m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;
    issue("multu",    4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 33, 0);

    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD;
    issue("div_neg",  4'b1010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 33, 0);

    m_hi = 32'h0; m_lo = 32'h80000000;
    issue("div_min",  4'b1010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 33, 0);

    m_hi = 32'd100; m_lo = 32'hFFFFFFFF;
    issue("divu_0",   4'b1011, 32'd100,      32'd0,        32'hFFFFFFFF, 0, 0, 33, 0);
    wait_out("divu_0");
    issue("mfhi_d",   4'b1100, 32'h0,        32'h0,        32'd100,      0, 0, 0, 0);
    issue("mflo_d",   4'b1101, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 0, 0);

    // Abort a DIVU with reset partway through
    issue("divu_abort", 4'b1011, 32'd1000, 32'd7, 32'd142, 0, 0, 33, 0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst.result", result, 32'd0);
    check("arst.out_valid", {31'b0, out_valid}, 32'd0);
    check("arst.overflow", {31'b0, overflow}, 32'd0);
    check("arst.zero", {31'b0, zero}, 32'd0);
    check("arst.hi", hi, 32'd0);
    check("arst.lo", lo, 32'd0);
    check("arst.in_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    m_hi = 0; m_lo = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue("add_post", 4'b0010, 32'd1, 32'd2, 32'd3, 0, 0, 0, 0);

    // Drain, then idle long enough to catch a stray pulse from the aborted op
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (40) @(posedge clk);
    #1;
    check("drain.pending", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, registered successor to the combinational datapath ALU. It adds signed/unsigned compare, add/sub overflow and zero flags, and an iterative multiply/divide unit with architectural HI/LO registers. It sits in the EX stage of the MIPS pipeline behind a valid/ready handshake: single-cycle ops complete in one cycle, and MULT/DIV hold the unit busy until done.

## Interface
- WIDTH, 32, operand/result width in bits (≥4, even)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- num1  in  WIDTH  operand A (rs)
- num2  in  WIDTH  operand B (rt)
- op  in  4  operation select
- in_valid  in  1  operands/op valid this cycle
- in_ready  out  1  unit can accept an op (high only in IDLE)
- result  out  WIDTH  registered result
- out_valid  out  1  one-cycle pulse; result/flags valid
- overflow  out  1  signed overflow of ADD/SUB, registered with result
- zero  out  1  result == 0, registered with result
- hi  out  WIDTH  HI register (product high half / remainder)
- lo  out  WIDTH  LO register (product low half / quotient)

## Operation
- Accept on a rising edge with in_valid && in_ready. in_valid without in_ready is ignored, not queued.
- Single-cycle ops (result written at the accept edge):
  - 0000 AND
  - 0001 OR
  - 0010 ADD, wraps
  - 0011 SLTU (unsigned a<b → 1 else 0)
  - 0100 A & ~B
  - 0101 A | ~B
  - 0110 SUB, wraps
  - 0111 SLT (signed compare)
  - 1100 MFHI (result=hi)
  - 1101 MFLO (result=lo)
  - 1110/1111 reserved: result 0, zero 1
- overflow is 1 only for ADD/SUB with two's-complement signed overflow; 0 for all other ops.
- Multi-cycle ops:
  - 1000 MULT (signed)
  - 1001 MULTU
  - 1010 DIV (signed)
  - 1011 DIVU
- MULT/DIV algorithm: operate on magnitudes (absolute values for signed ops), shift-add multiply / restoring divide, one bit per cycle, then correct sign.
  - Product: {hi,lo} = 2·WIDTH-bit product.
  - Division: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero: lo = all ones, hi = num1.
  - Signed most-negative ÷ −1: lo = most negative, hi = 0.
- On MULT/DIV completion: result = new lo, zero = (new lo == 0), overflow = 0.
- State machine (in_ready = (state==IDLE)):
  - IDLE → BUSY on accepting a MULT/DIV.
  - BUSY: iteration counter 0..WIDTH−1; → FIX when the count reaches WIDTH−1.
  - FIX: sign correction; hi, lo, result written; out_valid pulses; → IDLE.
- hi/lo change only at a FIX edge (or reset). Single-cycle ops never modify them.
- Operands and op are latched at accept. Input changes during BUSY have no effect.

## Timing
- Reset values:
  - result 0, overflow 0, zero 0, out_valid 0, hi 0, lo 0
  - state IDLE, in_ready 1
- Reset asserted mid-operation aborts MULT/DIV immediately. hi/lo return to 0 and no out_valid is produced.
- Single-cycle op accepted at edge E: result, flags and out_valid=1 hold for the cycle after E. Back-to-back issue is allowed every cycle.
- MULT/DIV accepted at edge E0:
  - in_ready is 0 from E0 until the FIX edge E0+WIDTH+1.
  - out_valid=1 in the cycle after E0+WIDTH+1.
  - in_ready is 1 in that same cycle, so a new op may be accepted at the next edge.
- Total MULT/DIV latency is WIDTH+1 cycles (33 at WIDTH=32), independent of operand values, including divide by zero.
- MFHI/MFLO issued in the cycle out_valid of a MULT/DIV is high returns the new hi/lo.
- No output backpressure. The consumer must capture on out_valid. out_valid is never high two cycles for one op.
- Between pulses, result and flags hold their last values.

## Test plan
- Reset mid-run: reset asserted during a DIVU → async clear of all outputs and in_ready=1. Afterward, ADD 1+2 → result 3.
- ALU sweep, WIDTH=32:
  - ADD 0x7FFFFFFF+1 → 0x80000000, overflow 1
  - SUB 5−5 → 0, zero 1
  - SLT 0xFFFFFFFF vs 1 → 1
  - SLTU same operands → 0
  - A&~B with 0xF0F0, 0x00FF → 0xF000
  - reserved op 1111 → 0, zero 1
- Multiply, including in_valid held high during BUSY with other ops (must be ignored):
  - MULT 0xFFFFFFFE × 3 → hi 0xFFFFFFFF, lo 0xFFFFFFFA, out_valid exactly 33 cycles after accept
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi 0xFFFFFFFE, lo 0x00000001
- Signed divide:
  - DIV −7 ÷ 2 → lo 0xFFFFFFFD (−3), hi 0xFFFFFFFF (−1)
  - DIV 0x80000000 ÷ 0xFFFFFFFF → lo 0x80000000, hi 0
- Unsigned divide and readback:
  - DIVU 100 ÷ 0 → lo 0xFFFFFFFF, hi 100, latency 33
  - MFHI issued in the same cycle as out_valid → 100 on the next out_valid
